// File: rtl/q_pkg.sv
// Shared definitions for the signed Q result path: default sample width,
// sample type and the upstream pipeline latency that sizes the FIFO throttle.
package q_pkg;

   localparam int Q_DATA_W       = 16;
   localparam int Q_UPSTREAM_LAT = 5;

   typedef logic signed [Q_DATA_W-1:0] q_t;

endpackage : q_pkg

// File: rtl/q_fifo_mem.sv
// DEPTH x DATA_WIDTH storage for the result FIFO: one synchronous write port,
// one asynchronous read port. Contents are intentionally not reset.
module q_fifo_mem
   import q_pkg::*;
#(
   parameter int DATA_WIDTH = Q_DATA_W,
   parameter int DEPTH      = 8
) (
   input  logic                         clk,
   input  logic                         we,
   input  logic [$clog2(DEPTH)-1:0]     waddr,
   input  logic signed [DATA_WIDTH-1:0] wdata,
   input  logic [$clog2(DEPTH)-1:0]     raddr,
   output logic signed [DATA_WIDTH-1:0] rdata
);

   logic signed [DATA_WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule : q_fifo_mem

// File: rtl/q_result_fifo.sv
// Output FIFO behind the no-backpressure Q pipeline: valid/ready consumer side,
// early afull throttle and sticky overflow. Define Q_FIFO_STATS_EN for q_min/q_max.
module q_result_fifo
   import q_pkg::*;
#(
   parameter int DATA_WIDTH   = Q_DATA_W,
   parameter int DEPTH        = 8,
   parameter int AFULL_MARGIN = Q_UPSTREAM_LAT
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_vld,
   input  logic signed [DATA_WIDTH-1:0] in_data,
   output logic                         afull,
   output logic                         out_vld,
   output logic signed [DATA_WIDTH-1:0] out_data,
   input  logic                         out_rdy,
   output logic [$clog2(DEPTH):0]       count,
`ifdef Q_FIFO_STATS_EN
   output logic signed [DATA_WIDTH-1:0] q_min,
   output logic signed [DATA_WIDTH-1:0] q_max,
`endif
   output logic                         ovf,
   input  logic                         ovf_clr
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
   localparam logic [CW-1:0] AFULL_CNT = CW'(DEPTH - AFULL_MARGIN);

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;
   logic          push, pop, drop;
   logic signed [DATA_WIDTH-1:0] rdata;

   assign out_vld = (count_q != '0);
   assign pop     = out_vld & out_rdy;
   // A full FIFO can still take a sample when the head leaves in the same cycle.
   assign push    = in_vld & ((count_q < FULL_CNT) | pop);
   assign drop    = in_vld & ~push;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push & ~pop)      count_d = count_q + 1'b1;
      else if (pop & ~push) count_d = count_q - 1'b1;
      // Losing a sample outranks a concurrent clear.
      if (drop)         ovf_d = 1'b1;
      else if (ovf_clr) ovf_d = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   q_fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr_q),
      .wdata (in_data),
      .raddr (rd_ptr_q),
      .rdata (rdata)
   );

   assign out_data = out_vld ? rdata : '0;
   assign count    = count_q;
   assign ovf      = ovf_q;
   assign afull    = (count_q >= AFULL_CNT);

`ifdef Q_FIFO_STATS_EN
   function automatic logic signed [DATA_WIDTH-1:0] most_pos();
      return {1'b0, {(DATA_WIDTH-1){1'b1}}};
   endfunction

   function automatic logic signed [DATA_WIDTH-1:0] most_neg();
      return {1'b1, {(DATA_WIDTH-1){1'b0}}};
   endfunction

   logic signed [DATA_WIDTH-1:0] q_min_q, q_min_d, q_max_q, q_max_d;
   logic signed [DATA_WIDTH-1:0] min_base, max_base;

   // A push alongside ovf_clr is folded in after the clear.
   always_comb begin
      min_base = ovf_clr ? most_pos() : q_min_q;
      max_base = ovf_clr ? most_neg() : q_max_q;
      q_min_d  = min_base;
      q_max_d  = max_base;
      if (push && (in_data < min_base)) q_min_d = in_data;
      if (push && (in_data > max_base)) q_max_d = in_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_min_q <= most_pos();
         q_max_q <= most_neg();
      end else begin
         q_min_q <= q_min_d;
         q_max_q <= q_max_d;
      end
   end

   assign q_min = q_min_q;
   assign q_max = q_max_q;
`endif

endmodule : q_result_fifo

// File: tb/tb_q_result_fifo.sv
// Self-checking bench for q_result_fifo against a queue-based reference model.
module tb_q_result_fifo;

   localparam int DW    = 16;
   localparam int DEPTH = 8;
   localparam int AM    = 5;
   localparam logic signed [DW-1:0] HI = 16'sh7FFF;
   localparam logic signed [DW-1:0] LO = 16'sh8000;

   logic clk = 1'b0;
   logic rst;
   logic in_vld;
   logic signed [DW-1:0] in_data;
   logic afull, out_vld, out_rdy, ovf, ovf_clr;
   logic signed [DW-1:0] out_data;
   logic [$clog2(DEPTH):0] count;
`ifdef Q_FIFO_STATS_EN
   logic signed [DW-1:0] q_min, q_max;
`endif

   int vectors = 0;
   int miscompares = 0;

   logic signed [DW-1:0] mq[$];
   logic signed [DW-1:0] last_pop;
   logic m_ovf;
   logic signed [DW-1:0] m_min, m_max;

   always #5 clk = ~clk;

   q_result_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_MARGIN(AM)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_vld   (in_vld),
      .in_data  (in_data),
      .afull    (afull),
      .out_vld  (out_vld),
      .out_data (out_data),
      .out_rdy  (out_rdy),
      .count    (count),
`ifdef Q_FIFO_STATS_EN
      .q_min    (q_min),
      .q_max    (q_max),
`endif
      .ovf      (ovf),
      .ovf_clr  (ovf_clr)
   );

   task automatic model_reset();
      mq.delete();
      m_ovf = 1'b0;
      m_min = HI;
      m_max = LO;
   endtask

   // One clock of stimulus; the model applies the FIFO rules to the same inputs.
   task automatic step(input logic vld, input logic signed [DW-1:0] d,
                       input logic rdy, input logic clr);
      bit pop, push, drop;
      in_vld  = vld;
      in_data = d;
      out_rdy = rdy;
      ovf_clr = clr;
      pop  = (mq.size() != 0) && rdy;
      push = vld && ((mq.size() < DEPTH) || pop);
      drop = vld && !push;
      @(posedge clk);
      #1;
      if (pop) last_pop = mq.pop_front();
      if (push) mq.push_back(d);
      if (drop) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      if (clr) begin
         m_min = HI;
         m_max = LO;
      end
      if (push) begin
         if (d < m_min) m_min = d;
         if (d > m_max) m_max = d;
      end
      in_vld  = 1'b0;
      in_data = '0;
      out_rdy = 1'b0;
      ovf_clr = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_vld = 1'b0; in_data = '0; out_rdy = 1'b0; ovf_clr = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      vectors++; if (count !== '0) begin miscompares++; $display("FAIL reset_count got=%0d exp=0", count); end
      vectors++; if (out_vld !== 1'b0) begin miscompares++; $display("FAIL reset_out_vld got=%b exp=0", out_vld); end
      vectors++; if (afull !== 1'b0) begin miscompares++; $display("FAIL reset_afull got=%b exp=0", afull); end
      vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
      vectors++; if (out_data !== '0) begin miscompares++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
      rst = 1'b0;
   endtask

   task automatic test_single_push();
      step(1'b1, -16'sd7, 1'b0, 1'b0);
      vectors++; if (out_vld !== 1'b1) begin miscompares++; $display("FAIL single_out_vld got=%b exp=1", out_vld); end
      vectors++; if (out_data !== 16'hFFF9) begin miscompares++; $display("FAIL single_out_data got=%h exp=fff9", out_data); end
      vectors++; if (int'(count) !== 1) begin miscompares++; $display("FAIL single_count got=%0d exp=1", count); end
   endtask

   task automatic test_reset_mid();
      step(1'b1, 16'sd21, 1'b0, 1'b0);
      step(1'b1, 16'sd22, 1'b0, 1'b0);
      vectors++; if (int'(count) !== 3) begin miscompares++; $display("FAIL mid_pre_count got=%0d exp=3", count); end
      in_vld = 1'b1; in_data = 16'sd23; out_rdy = 1'b1;
      #2 rst = 1'b1;
      #1;
      vectors++; if (count !== '0) begin miscompares++; $display("FAIL mid_count got=%0d exp=0", count); end
      vectors++; if (out_vld !== 1'b0) begin miscompares++; $display("FAIL mid_out_vld got=%b exp=0", out_vld); end
      vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL mid_ovf got=%b exp=0", ovf); end
      vectors++; if (out_data !== '0) begin miscompares++; $display("FAIL mid_out_data got=%h exp=0", out_data); end
      in_vld = 1'b0; in_data = '0; out_rdy = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_fill_overflow();
      for (int i = 1; i <= DEPTH; i++) begin
         step(1'b1, DW'(i), 1'b0, 1'b0);
         vectors++; if (int'(count) !== i) begin miscompares++; $display("FAIL fill_count got=%0d exp=%0d", count, i); end
         vectors++; if (afull !== (i >= 3)) begin miscompares++; $display("FAIL fill_afull at=%0d got=%b exp=%b", i, afull, (i >= 3)); end
      end
      vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL fill_ovf got=%b exp=0", ovf); end
      step(1'b1, 16'sd9, 1'b0, 1'b0);
      vectors++; if (ovf !== 1'b1) begin miscompares++; $display("FAIL ovf_set got=%b exp=1", ovf); end
      vectors++; if (int'(count) !== DEPTH) begin miscompares++; $display("FAIL ovf_count got=%0d exp=%0d", count, DEPTH); end
      for (int i = 1; i <= DEPTH; i++) begin
         vectors++; if (out_data !== DW'(i)) begin miscompares++; $display("FAIL drain_data got=%0d exp=%0d", out_data, i); end
         step(1'b0, '0, 1'b1, 1'b0);
      end
      vectors++; if (out_vld !== 1'b0) begin miscompares++; $display("FAIL drain_empty got=%b exp=0", out_vld); end
      vectors++; if (ovf !== 1'b1) begin miscompares++; $display("FAIL drain_ovf_sticky got=%b exp=1", ovf); end
   endtask

   task automatic test_full_push_pop();
      step(1'b0, '0, 1'b0, 1'b1);
      vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL clr_alone got=%b exp=0", ovf); end
      for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(11 + i), 1'b0, 1'b0);
      step(1'b1, 16'sd100, 1'b1, 1'b0);
      vectors++; if (int'(count) !== DEPTH) begin miscompares++; $display("FAIL pp_count got=%0d exp=%0d", count, DEPTH); end
      vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL pp_ovf got=%b exp=0", ovf); end
      vectors++; if (out_data !== 16'sd12) begin miscompares++; $display("FAIL pp_head got=%0d exp=12", out_data); end
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b0, '0, 1'b1, 1'b0);
         vectors++;
         if (last_pop !== ((i < DEPTH - 1) ? DW'(12 + i) : 16'sd100)) begin
            miscompares++; $display("FAIL pp_drain idx=%0d got=%0d", i, last_pop);
         end
      end
   endtask

   task automatic test_wrap();
      logic signed [DW-1:0] d;
      for (int i = 0; i < 4; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         d = DW'($urandom);
         step(1'b1, d, 1'b1, 1'b0);
         vectors++; if (int'(count) !== 4) begin miscompares++; $display("FAIL wrap_count got=%0d exp=4", count); end
         vectors++; if (out_data !== mq[0]) begin miscompares++; $display("FAIL wrap_data got=%h exp=%h", out_data, mq[0]); end
      end
      while (mq.size() != 0) begin
         vectors++; if (out_data !== mq[0]) begin miscompares++; $display("FAIL wrap_drain got=%h exp=%h", out_data, mq[0]); end
         step(1'b0, '0, 1'b1, 1'b0);
      end
   endtask

   task automatic test_ovf_clr();
      for (int i = 0; i < DEPTH; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
      step(1'b1, 16'sd55, 1'b0, 1'b1);
      vectors++; if (ovf !== 1'b1) begin miscompares++; $display("FAIL clr_vs_drop got=%b exp=1", ovf); end
      step(1'b0, '0, 1'b0, 1'b1);
      vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL clr_after got=%b exp=0", ovf); end
      while (mq.size() != 0) step(1'b0, '0, 1'b1, 1'b0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         step(($urandom % 4) != 0, DW'($urandom), $urandom % 2, ($urandom % 32) == 0);
         vectors++; if (int'(count) !== mq.size()) begin miscompares++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", i, count, mq.size()); end
         vectors++; if (out_vld !== (mq.size() != 0)) begin miscompares++; $display("FAIL rnd_out_vld cyc=%0d got=%b", i, out_vld); end
         vectors++; if (out_data !== ((mq.size() != 0) ? mq[0] : '0)) begin miscompares++; $display("FAIL rnd_out_data cyc=%0d got=%h", i, out_data); end
         vectors++; if (afull !== (mq.size() >= DEPTH - AM)) begin miscompares++; $display("FAIL rnd_afull cyc=%0d got=%b", i, afull); end
         vectors++; if (ovf !== m_ovf) begin miscompares++; $display("FAIL rnd_ovf cyc=%0d got=%b exp=%b", i, ovf, m_ovf); end
`ifdef Q_FIFO_STATS_EN
         vectors++; if (q_min !== m_min) begin miscompares++; $display("FAIL rnd_q_min cyc=%0d got=%0d exp=%0d", i, q_min, m_min); end
         vectors++; if (q_max !== m_max) begin miscompares++; $display("FAIL rnd_q_max cyc=%0d got=%0d exp=%0d", i, q_max, m_max); end
`endif
      end
      while (mq.size() != 0) step(1'b0, '0, 1'b1, 1'b0);
   endtask

`ifdef Q_FIFO_STATS_EN
   task automatic test_stats();
      step(1'b0, '0, 1'b0, 1'b1);
      step(1'b1, -16'sd32768, 1'b1, 1'b0);
      step(1'b1, 16'sd5, 1'b1, 1'b0);
      step(1'b1, 16'sd32767, 1'b1, 1'b0);
      vectors++; if (q_min !== LO) begin miscompares++; $display("FAIL stats_min got=%0d exp=-32768", q_min); end
      vectors++; if (q_max !== HI) begin miscompares++; $display("FAIL stats_max got=%0d exp=32767", q_max); end
      step(1'b0, '0, 1'b1, 1'b1);
      vectors++; if (q_min !== HI) begin miscompares++; $display("FAIL stats_clr_min got=%0d exp=32767", q_min); end
      vectors++; if (q_max !== LO) begin miscompares++; $display("FAIL stats_clr_max got=%0d exp=-32768", q_max); end
      while (mq.size() != 0) step(1'b0, '0, 1'b1, 1'b0);
   endtask
`endif

   initial begin
      test_reset();
      test_single_push();
      test_reset_mid();
      test_fill_overflow();
      test_full_push_pop();
      test_wrap();
      test_ovf_clr();
      test_random();
`ifdef Q_FIFO_STATS_EN
      test_stats();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_q_result_fifo

// File: doc/q_result_fifo.md
Name: q_result_fifo

Overview:
- Output stage directly downstream of the signed Q-computation pipeline.
- The compute pipeline has no backpressure: it emits one signed Q per cycle, marked by a valid strobe.
- This block buffers those results in a small synchronous FIFO and presents them to a consumer with valid/ready handshake.
- It raises an almost-full throttle early enough to cover the upstream in-flight results, and records any lost result in a sticky overflow flag.

Parameters:
- DATA_WIDTH, 16, width of signed Q samples; must equal the upstream DATA_WIDTH.
- DEPTH, 8, FIFO entries; must be a power of 2 and >= 2.
- AFULL_MARGIN, 5, free entries reserved for upstream in-flight results; equals upstream input-to-output latency in cycles; must be < DEPTH.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_vld  in  1  upstream result valid (driven from Q_vld).
- in_data  in  DATA_WIDTH  signed upstream result (driven from Q).
- afull  out  1  throttle; upstream source must stop asserting data_vld while high.
- out_vld  out  1  FIFO non-empty; out_data valid.
- out_data  out  DATA_WIDTH  signed head-of-FIFO value.
- out_rdy  in  1  consumer accepts head when out_vld & out_rdy.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- ovf  out  1  sticky: an in_vld result was dropped.
- ovf_clr  in  1  clears ovf (and stats, if compiled in).

Behaviour:
- Reset (async, active-high): rd_ptr = wr_ptr = 0, count = 0, out_vld = 0, afull = 0, ovf = 0. out_data = 0 while empty; memory contents are not reset.
- Push = in_vld & (count < DEPTH | pop). Pop = out_vld & out_rdy.
- Pointers are $clog2(DEPTH) bits and wrap naturally at DEPTH.
- count updates each cycle: +1 on push only, -1 on pop only, unchanged on both or neither.
- out_vld = (count != 0), from registered state.
- out_data = mem[rd_ptr] (array read); driven to 0 when empty.
- No fall-through: a push into an empty FIFO gives out_vld = 1 on the next cycle. Input-to-output latency is 1 cycle minimum.
- Empty with in_vld & out_rdy in the same cycle: pop is 0, push is 1.
- Full with in_vld & pop in the same cycle: both happen, count stays DEPTH, no overflow.
- Full with in_vld and no pop: sample dropped; memory, pointers and count unchanged; ovf <= 1 on the next edge.
- ovf_clr and a drop in the same cycle: set wins, ovf stays 1.
- afull = (count >= DEPTH - AFULL_MARGIN), combinational from registered count.
- Upstream respecting afull never overflows: up to AFULL_MARGIN results may still arrive after afull rises.
- out_vld & !out_rdy: out_data holds stable until accepted (consumer stall).
- No arithmetic on data; samples are stored bit-exact, sign preserved.
- Reset mid-stream empties the FIFO immediately; any partially accepted transfer is discarded.

Optional Feature:
- Macro Q_FIFO_STATS_EN.
- Defined: adds outputs q_min and q_max (DATA_WIDTH, signed) tracking the extremes of all pushed samples.
  - Reset / ovf_clr value: q_min = most positive, q_max = most negative.
  - Updated on the cycle after each push using a signed compare.
  - A push in the same cycle as ovf_clr is included after the clear.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package q_pkg:
  - default DATA_WIDTH constant;
  - q_t typedef (logic signed [DATA_WIDTH-1:0]);
  - constant for upstream latency (5), used as the AFULL_MARGIN default.
- One sub-module, q_fifo_mem: DEPTH x DATA_WIDTH register array with write port (we, waddr, wdata) and asynchronous read port.
- Pointer, count, flag and stats logic stay in the top module.

Test Plan:
- Reset mid-operation: with 3 entries held, assert rst -> count = 0, out_vld = 0 and ovf = 0 immediately; out_data = 0.
- Single push: in_vld = 1, in_data = -7, out_rdy = 0 -> next cycle out_vld = 1, out_data = -7 (0xFFF9), count = 1.
- Fill, DEPTH = 8, AFULL_MARGIN = 5: 8 consecutive pushes 1..8 with out_rdy = 0 -> afull rises when count = 3; count reaches 8.
- Overflow: a 9th push (value 9) while full -> ovf = 1. Draining with out_rdy = 1 yields 1..8 in order, not 9.
- Simultaneous push/pop at full: in_vld = 1, value 100, plus out_rdy = 1 -> count stays 8, ovf stays 0, 100 exits last. Pointer wrap is checked over 20 continuous cycles with data intact.
- ovf_clr with a concurrent drop -> ovf remains 1; ovf_clr alone -> ovf = 0.
- Stats (with Q_FIFO_STATS_EN): push -32768, 5, 32767 -> q_min = -32768, q_max = 32767; after ovf_clr -> q_min = 32767, q_max = -32768.
